// File: rtl/tile_reduce_accum.sv
// Tile column-reduction accumulator: reduces a ROWS x COLS signed tile to one
// COLS-lane vector per beat, with MAC / OUTER / MAX modes, group tracking,
// per-lane output narrowing and valid/ready handshakes on both sides.
module tile_reduce_accum #(
   parameter int unsigned ROWS      = 4,
   parameter int unsigned COLS      = 4,
   parameter int unsigned IN_WIDTH  = 32,
   parameter int unsigned ACC_WIDTH = 40,
   parameter int unsigned OUT_WIDTH = 32,
   parameter bit          SAT_EN    = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [1:0]                      in_mode,
   input  logic                            in_clear,
   input  logic                            in_last,
   input  logic [ROWS*COLS*IN_WIDTH-1:0]   mat_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [COLS*OUT_WIDTH-1:0]       vec_out,
   output logic [COLS-1:0]                 out_sat,
   output logic [15:0]                     out_count
);

   localparam int unsigned LEVELS = $clog2(ROWS);
   localparam int unsigned CNT_W  = 16;
   localparam logic [ACC_WIDTH-1:0] OUT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      MODE_MAC   = 2'b00,
      MODE_OUTER = 2'b01,
      MODE_MAX   = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   logic                              adv_c;
   logic [ACC_WIDTH-1:0]              tree_c [2*ROWS];
   logic [COLS-1:0][ACC_WIDTH-1:0]    col_sum_c;

   logic                              s0_valid_q, s0_valid_d;
   mode_e                             s0_mode_q, s0_mode_d;
   logic                              s0_clear_q, s0_clear_d;
   logic                              s0_last_q, s0_last_d;
   logic [COLS-1:0][ACC_WIDTH-1:0]    s0_sum_q, s0_sum_d;

   logic [COLS-1:0][ACC_WIDTH-1:0]    acc_q, acc_d;
   logic                              group_open_q, group_open_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;

   logic                              out_valid_q, out_valid_d;
   logic [COLS*OUT_WIDTH-1:0]         vec_out_q, vec_out_d;
   logic [COLS-1:0]                   out_sat_q, out_sat_d;
   logic [CNT_W-1:0]                  out_count_q, out_count_d;

   logic                              first_c;
   logic                              emit_c;
   logic [COLS-1:0][ACC_WIDTH-1:0]    emit_src_c;
   logic [CNT_W-1:0]                  emit_cnt_c;
   logic [CNT_W-1:0]                  cnt_next_c;

   // Whole pipeline advances together; a stalled output holds every stage.
   assign adv_c    = !out_valid_q || out_ready;
   assign in_ready = adv_c;

   // Balanced adder tree per column; zero padding carries odd leftovers up a level.
   always_comb begin
      col_sum_c = '0;
      for (int r = 0; r < 2*ROWS; r++) tree_c[r] = '0;
      for (int c = 0; c < COLS; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            tree_c[r] = ACC_WIDTH'($signed(mat_in[(r*COLS+c)*IN_WIDTH +: IN_WIDTH]));
         end
         for (int r = ROWS; r < 2*ROWS; r++) begin
            tree_c[r] = '0;
         end
         for (int lvl = 0; lvl < LEVELS; lvl++) begin
            for (int r = 0; r < ROWS; r++) begin
               if ((r % (2 << lvl)) == 0) begin
                  tree_c[r] = tree_c[r] + tree_c[r + (1 << lvl)];
               end
            end
         end
         col_sum_c[c] = tree_c[0];
      end
   end

   // Stage 0: capture column sums and beat controls on accept.
   always_comb begin
      s0_valid_d = s0_valid_q;
      s0_mode_d  = s0_mode_q;
      s0_clear_d = s0_clear_q;
      s0_last_d  = s0_last_q;
      s0_sum_d   = s0_sum_q;
      if (adv_c) begin
         s0_valid_d = in_valid;
         if (in_valid) begin
            s0_mode_d  = mode_e'(in_mode);
            s0_clear_d = in_clear;
            s0_last_d  = in_last;
            s0_sum_d   = col_sum_c;
         end
      end
   end

   // Stage 1: accumulate / max / pass-through, group tracking and output narrowing.
   always_comb begin
      acc_d        = acc_q;
      group_open_d = group_open_q;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      vec_out_d    = vec_out_q;
      out_sat_d    = out_sat_q;
      out_count_d  = out_count_q;
      emit_c       = 1'b0;
      emit_src_c   = acc_q;
      emit_cnt_c   = cnt_q;
      first_c      = s0_clear_q || !group_open_q;
      cnt_next_c   = first_c ? CNT_W'(1)
                             : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1));
      if (adv_c) begin
         if (s0_valid_q) begin
            case (s0_mode_q)
               MODE_MAC, MODE_MAX: begin
                  for (int c = 0; c < COLS; c++) begin
                     if (first_c) begin
                        acc_d[c] = s0_sum_q[c];
                     end else if (s0_mode_q == MODE_MAC) begin
                        acc_d[c] = acc_q[c] + s0_sum_q[c];
                     end else if ($signed(s0_sum_q[c]) > $signed(acc_q[c])) begin
                        acc_d[c] = s0_sum_q[c];
                     end else begin
                        acc_d[c] = acc_q[c];
                     end
                  end
                  cnt_d        = cnt_next_c;
                  group_open_d = 1'b1;
                  if (s0_last_q) begin
                     emit_c       = 1'b1;
                     emit_src_c   = acc_d;
                     emit_cnt_c   = cnt_d;
                     group_open_d = 1'b0;
                  end
               end
               MODE_OUTER: begin
                  emit_c     = 1'b1;
                  emit_src_c = s0_sum_q;
                  emit_cnt_c = CNT_W'(1);
               end
               default: begin
                  if (s0_last_q && group_open_q) begin
                     emit_c       = 1'b1;
                     emit_src_c   = acc_q;
                     emit_cnt_c   = cnt_q;
                     group_open_d = 1'b0;
                  end
               end
            endcase
         end
         out_valid_d = emit_c;
         if (emit_c) begin
            out_count_d = emit_cnt_c;
            for (int c = 0; c < COLS; c++) begin
               if (SAT_EN && ($signed(emit_src_c[c]) > $signed(OUT_MAX))) begin
                  vec_out_d[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OUT_MAX);
                  out_sat_d[c] = 1'b1;
               end else if (SAT_EN && ($signed(emit_src_c[c]) < $signed(OUT_MIN))) begin
                  vec_out_d[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(OUT_MIN);
                  out_sat_d[c] = 1'b1;
               end else begin
                  vec_out_d[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(emit_src_c[c]);
                  out_sat_d[c] = 1'b0;
               end
            end
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_valid_q   <= 1'b0;
         s0_mode_q    <= MODE_MAC;
         s0_clear_q   <= 1'b0;
         s0_last_q    <= 1'b0;
         s0_sum_q     <= '0;
         acc_q        <= '0;
         group_open_q <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         vec_out_q    <= '0;
         out_sat_q    <= '0;
         out_count_q  <= '0;
      end else begin
         s0_valid_q   <= s0_valid_d;
         s0_mode_q    <= s0_mode_d;
         s0_clear_q   <= s0_clear_d;
         s0_last_q    <= s0_last_d;
         s0_sum_q     <= s0_sum_d;
         acc_q        <= acc_d;
         group_open_q <= group_open_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         vec_out_q    <= vec_out_d;
         out_sat_q    <= out_sat_d;
         out_count_q  <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign vec_out   = vec_out_q;
   assign out_sat   = out_sat_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_tile_reduce_accum.sv
// Scoreboard bench for tile_reduce_accum: instance A (4x4, saturating) and
// instance B (5x3, truncating) driven with directed and random beats.
module tb_tile_reduce_accum;

   localparam int A_R = 4, A_C = 4, B_R = 5, B_C = 3;
   localparam int IW = 32, AW = 40, OW = 32;
   localparam longint OMAX = 64'sd2147483647;
   localparam longint OMIN = -64'sd2147483648;

   typedef struct packed {
      logic [7:0][31:0] v;
      logic [7:0]       s;
      logic [15:0]      cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic                    a_in_valid, a_in_ready, a_in_clear, a_in_last;
   logic [1:0]              a_in_mode;
   logic [A_R*A_C*IW-1:0]   a_mat_in;
   logic                    a_out_valid, a_out_ready;
   logic [A_C*OW-1:0]       a_vec_out;
   logic [A_C-1:0]          a_out_sat;
   logic [15:0]             a_out_count;

   logic                    b_in_valid, b_in_ready, b_in_clear, b_in_last;
   logic [1:0]              b_in_mode;
   logic [B_R*B_C*IW-1:0]   b_mat_in;
   logic                    b_out_valid, b_out_ready;
   logic [B_C*OW-1:0]       b_vec_out;
   logic [B_C-1:0]          b_out_sat;
   logic [15:0]             b_out_count;

   tile_reduce_accum #(.ROWS(A_R), .COLS(A_C), .IN_WIDTH(IW), .ACC_WIDTH(AW),
                       .OUT_WIDTH(OW), .SAT_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_mode(a_in_mode), .in_clear(a_in_clear), .in_last(a_in_last),
      .mat_in(a_mat_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .vec_out(a_vec_out), .out_sat(a_out_sat), .out_count(a_out_count));

   tile_reduce_accum #(.ROWS(B_R), .COLS(B_C), .IN_WIDTH(IW), .ACC_WIDTH(AW),
                       .OUT_WIDTH(OW), .SAT_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_mode(b_in_mode), .in_clear(b_in_clear), .in_last(b_in_last),
      .mat_in(b_mat_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .vec_out(b_vec_out), .out_sat(b_out_sat), .out_count(b_out_count));

   int checks = 0;
   int errors = 0;
   int bp_mode = 0;
   int last_waits = 0;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   bit a_hold = 1'b0;
   logic [A_C*OW-1:0] a_hold_vec;

   longint tile [8][8];
   longint m_acc [2][8];
   bit     m_open [2];
   int     m_cnt [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint wrap_acc(input longint x);
      return (x <<< (64 - AW)) >>> (64 - AW);
   endfunction

   function automatic void narrow(input longint v, input bit sat,
                                  output logic [31:0] o, output logic s);
      s = 1'b0;
      o = v[31:0];
      if (sat && v > OMAX) begin
         o = 32'h7FFF_FFFF;
         s = 1'b1;
      end else if (sat && v < OMIN) begin
         o = 32'h8000_0000;
         s = 1'b1;
      end
   endfunction

   function automatic void model_reset(input int idx);
      m_open[idx] = 1'b0;
      m_cnt[idx]  = 0;
      for (int c = 0; c < 8; c++) m_acc[idx][c] = 0;
   endfunction

   // Reference behaviour of one accepted beat: column sums then mode rules.
   function automatic void model_beat(input int idx, input logic [1:0] mode,
                                      input bit clr, input bit last,
                                      output bit emit, output exp_t e);
      longint s [8];
      longint src [8];
      int rows, cols, ecnt;
      bit first, sat;
      logic [31:0] o;
      logic sb;
      rows = (idx == 0) ? A_R : B_R;
      cols = (idx == 0) ? A_C : B_C;
      sat  = (idx == 0);
      emit = 1'b0;
      e    = '0;
      ecnt = 0;
      for (int c = 0; c < 8; c++) begin
         s[c] = 0;
         src[c] = 0;
      end
      for (int c = 0; c < cols; c++)
         for (int r = 0; r < rows; r++) s[c] += tile[r][c];
      first = clr || !m_open[idx];
      case (mode)
         2'b00, 2'b10: begin
            for (int c = 0; c < cols; c++) begin
               if (first) m_acc[idx][c] = s[c];
               else if (mode == 2'b00) m_acc[idx][c] = wrap_acc(m_acc[idx][c] + s[c]);
               else if (s[c] > m_acc[idx][c]) m_acc[idx][c] = s[c];
            end
            m_cnt[idx]  = first ? 1 : ((m_cnt[idx] < 65535) ? m_cnt[idx] + 1 : 65535);
            m_open[idx] = 1'b1;
            if (last) begin
               emit = 1'b1;
               for (int c = 0; c < 8; c++) src[c] = m_acc[idx][c];
               ecnt = m_cnt[idx];
               m_open[idx] = 1'b0;
            end
         end
         2'b01: begin
            emit = 1'b1;
            for (int c = 0; c < 8; c++) src[c] = s[c];
            ecnt = 1;
         end
         default: begin
            if (last && m_open[idx]) begin
               emit = 1'b1;
               for (int c = 0; c < 8; c++) src[c] = m_acc[idx][c];
               ecnt = m_cnt[idx];
               m_open[idx] = 1'b0;
            end
         end
      endcase
      if (emit) begin
         for (int c = 0; c < cols; c++) begin
            narrow(src[c], sat, o, sb);
            e.v[c] = o;
            e.s[c] = sb;
         end
         e.cnt = 16'(ecnt);
      end
   endfunction

   function automatic longint rv();
      if ($urandom % 16 == 0) return longint'(int'($urandom));
      return longint'(int'($urandom)) >>> 12;
   endfunction

   function automatic void rand_tile();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) tile[r][c] = rv();
   endfunction

   function automatic void zero_tile();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) tile[r][c] = 0;
   endfunction

   // Present one beat to instance idx, wait (bounded) for acceptance, update the model.
   task automatic send(input int idx, input logic [1:0] mode, input bit clr, input bit last);
      int waits;
      bit emit;
      exp_t e;
      logic rdy;
      @(negedge clk);
      if (idx == 0) begin
         a_in_mode = mode; a_in_clear = clr; a_in_last = last;
         for (int r = 0; r < A_R; r++)
            for (int c = 0; c < A_C; c++) a_mat_in[(r*A_C+c)*IW +: IW] = tile[r][c][31:0];
         a_in_valid = 1'b1;
      end else begin
         b_in_mode = mode; b_in_clear = clr; b_in_last = last;
         for (int r = 0; r < B_R; r++)
            for (int c = 0; c < B_C; c++) b_mat_in[(r*B_C+c)*IW +: IW] = tile[r][c][31:0];
         b_in_valid = 1'b1;
      end
      #1;
      waits = 0;
      rdy = (idx == 0) ? a_in_ready : b_in_ready;
      while (!rdy && waits < 200) begin
         @(negedge clk);
         #1;
         waits++;
         rdy = (idx == 0) ? a_in_ready : b_in_ready;
      end
      if (!rdy) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: inst %0d in_ready stuck at 0", idx);
      end else begin
         model_beat(idx, mode, clr, last, emit, e);
         if (emit) begin
            if (idx == 0) qa.push_back(e);
            else qb.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      last_waits = waits;
      if (idx == 0) a_in_valid = 1'b0;
      else b_in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((qa.size() != 0 || qb.size() != 0) && w < 1000) begin
         @(posedge clk);
         w++;
      end
      repeat (3) @(posedge clk);
   endtask

   // Downstream ready for instance A: always, random, or held off.
   initial begin
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      forever begin
         @(negedge clk);
         case (bp_mode)
            0: a_out_ready = 1'b1;
            1: a_out_ready = ($urandom % 4) != 0;
            default: a_out_ready = 1'b0;
         endcase
      end
   end

   // Monitor A: compare on handshake, check vec_out stability while stalled.
   initial forever begin
      @(negedge clk);
      #2;
      if (rst_n && a_out_valid) begin
         if (a_out_ready) begin
            if (qa.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL a_unexpected_emit: vec %0h with empty queue", a_vec_out);
            end else begin
               ea = qa.pop_front();
               for (int c = 0; c < A_C; c++)
                  chk($sformatf("a_lane%0d", c), a_vec_out[c*OW +: OW], ea.v[c]);
               chk("a_sat", a_out_sat, ea.s[A_C-1:0]);
               chk("a_count", a_out_count, ea.cnt);
            end
            a_hold = 1'b0;
         end else begin
            if (a_hold) chk("a_stable_vec", 64'(a_vec_out == a_hold_vec), 64'd1);
            a_hold = 1'b1;
            a_hold_vec = a_vec_out;
         end
      end else begin
         a_hold = 1'b0;
      end
   end

   // Monitor B: always ready downstream.
   initial forever begin
      @(negedge clk);
      #2;
      if (rst_n && b_out_valid) begin
         if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_emit: vec %0h with empty queue", b_vec_out);
         end else begin
            eb = qb.pop_front();
            for (int c = 0; c < B_C; c++)
               chk($sformatf("b_lane%0d", c), b_vec_out[c*OW +: OW], eb.v[c]);
            chk("b_sat", b_out_sat, eb.s[B_C-1:0]);
            chk("b_count", b_out_count, eb.cnt);
         end
      end
   end

   initial begin
      int m;
      rst_n = 1'b0;
      a_in_valid = 1'b0; a_in_mode = 2'b00; a_in_clear = 1'b0; a_in_last = 1'b0; a_mat_in = '0;
      b_in_valid = 1'b0; b_in_mode = 2'b00; b_in_clear = 1'b0; b_in_last = 1'b0; b_mat_in = '0;
      model_reset(0);
      model_reset(1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_in_ready", a_in_ready, 1);
      chk("rst_out_valid", a_out_valid, 0);
      chk("rst_vec_out", 64'(a_vec_out == '0), 1);
      chk("rst_out_sat", a_out_sat, 0);
      chk("rst_out_count", a_out_count, 0);

      // All-ones MAC group of 3, with accept-to-valid latency.
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tile[r][c] = 1;
      send(0, 2'b00, 1'b0, 1'b0);
      send(0, 2'b00, 1'b0, 1'b0);
      send(0, 2'b00, 1'b0, 1'b1);
      chk("lat_stage0", a_out_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_emit", a_out_valid, 1);
      drain();

      // Back-to-back OUTER beats with mat_in[r][c]=r+c.
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tile[r][c] = r + c;
      for (int k = 0; k < 4; k++) begin
         send(0, 2'b01, 1'b0, 1'b0);
         chk("outer_in_ready", last_waits, 0);
      end
      drain();

      // MAX group with lane-0 row values 5, -7, 9.
      rand_tile();
      for (int r = 0; r < 8; r++) tile[r][0] = 5;
      send(0, 2'b10, 1'b1, 1'b0);
      rand_tile();
      for (int r = 0; r < 8; r++) tile[r][0] = -7;
      send(0, 2'b10, 1'b0, 1'b0);
      rand_tile();
      for (int r = 0; r < 8; r++) tile[r][0] = 9;
      send(0, 2'b10, 1'b0, 1'b1);
      drain();

      // Saturation (A) and truncation (B) on lane sums of +/-2^31 scale.
      zero_tile();
      for (int c = 0; c < 8; c++) tile[0][c] = OMAX;
      tile[0][1] = OMIN;
      send(0, 2'b00, 1'b1, 1'b0);
      send(0, 2'b00, 1'b0, 1'b1);
      send(1, 2'b00, 1'b1, 1'b0);
      send(1, 2'b00, 1'b0, 1'b1);
      drain();

      // Odd-leaf tree on B and simultaneous clear+last.
      for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) tile[r][c] = r * 3 - c * 7 + 1;
      send(1, 2'b01, 1'b0, 1'b0);
      rand_tile();
      send(1, 2'b00, 1'b0, 1'b0);
      rand_tile();
      send(1, 2'b00, 1'b1, 1'b1);
      rand_tile();
      send(0, 2'b00, 1'b0, 1'b0);
      rand_tile();
      send(0, 2'b00, 1'b1, 1'b1);
      drain();

      // Downstream stall with continuous input.
      bp_mode = 2;
      fork
         begin
            for (int k = 0; k < 8; k++) begin
               rand_tile();
               send(0, 2'b01, 1'b0, 1'b0);
            end
         end
         begin
            repeat (5) @(negedge clk);
            #1;
            chk("stall_in_ready", a_in_ready, 0);
            chk("stall_out_valid", a_out_valid, 1);
            bp_mode = 0;
         end
      join
      drain();

      // Reset in the middle of a MAC group, then a fresh cleared group.
      rand_tile();
      send(0, 2'b00, 1'b0, 1'b0);
      rand_tile();
      send(0, 2'b00, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      repeat (2) @(negedge clk);
      chk("midrst_out_valid", a_out_valid, 0);
      chk("midrst_out_count", a_out_count, 0);
      rst_n = 1'b1;
      rand_tile();
      send(0, 2'b00, 1'b1, 1'b0);
      rand_tile();
      send(0, 2'b00, 1'b0, 1'b1);
      drain();

      // Random traffic on both instances, random backpressure on A.
      bp_mode = 1;
      for (int k = 0; k < 300; k++) begin
         m = $urandom % 8;
         rand_tile();
         send((k % 3 == 2) ? 1 : 0,
              (m < 3) ? 2'b00 : (m < 5) ? 2'b10 : (m < 7) ? 2'b01 : 2'b11,
              ($urandom % 8) == 0, ($urandom % 4) == 0);
         if ($urandom % 4 == 0) @(negedge clk);
      end
      bp_mode = 0;
      drain();
      chk("qa_empty", qa.size(), 0);
      chk("qb_empty", qb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
